lsu_dmem_port: RTL

Load/store initiator between the core's execute stage and the single-port word-wide data memory (clk, we, addr, wdata, rdata; combinational read, write on posedge).
- Accepts one RV32 load/store per handshake.
- Aligns and sign/zero-extends load data.
- Implements byte/half stores as read-modify-write, because the memory has no byte strobes.
- Reports misaligned and out-of-range accesses without touching memory.

---
 rtl/lsu_dmem_port_if.sv | 45 ++++
 rtl/lsu_dmem_port.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/lsu_dmem_port_if.sv
// Handshake bundles for lsu_dmem_port: core-side request/response
// and the word-wide single-port data memory bus.
interface lsu_req_if #(
  parameter int ADDR_WIDTH = 32
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_we;
  logic [1:0]            req_size;
  logic                  req_unsigned;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [31:0]           req_wdata;
  logic                  rsp_valid;
  logic [31:0]           rsp_rdata;
  logic                  rsp_err;

  modport master (
    output req_valid, req_we, req_size,
    output req_unsigned, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_size,
    input  req_unsigned, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

interface dmem_if;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  modport master (
    output mem_we, mem_addr, mem_wdata,
    input  mem_rdata
  );

  modport slave (
    input  mem_we, mem_addr, mem_wdata,
    output mem_rdata
  );
endinterface

// File: rtl/lsu_dmem_port.sv
// RV32 load/store initiator for a word-wide dmem without byte strobes.
// Define LSU_FAULT_ADDR_EN to add the fault_addr/fault_cause outputs.
module lsu_dmem_port #(
  parameter int DMEM_WORDS = 256,
  parameter int ADDR_WIDTH = 32
) (
  input  logic     clk,
  input  logic     rst_n,
  lsu_req_if.slave req,
  dmem_if.master   mem
`ifdef LSU_FAULT_ADDR_EN
  ,
  output logic [31:0] fault_addr,
  output logic [1:0]  fault_cause
`endif
);

  localparam int IW = ADDR_WIDTH - 2;
  localparam logic [IW-1:0] NWORDS = IW'(DMEM_WORDS);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    RMW_RD,
    WRITE,
    RESP
  } state_t;

  typedef struct packed {
    logic [1:0]  lane;
    logic [1:0]  size;
    logic        uns;
    logic [15:0] wdata;
  } lreq_t;

  state_t      state;
  lreq_t       lr;
  logic        rsp_valid_q;
  logic        rsp_err_q;
  logic [31:0] rsp_rdata_q;
  logic        we_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;

  logic          ready;
  logic          accept;
  logic [IW-1:0] widx;
  logic          mis;
  logic          bad_size;
  logic          oor;
  logic          err;

  assign ready    = (state == IDLE);
  assign accept   = req.req_valid & ready;
  assign widx     = req.req_addr[ADDR_WIDTH-1:2];
  assign bad_size = (req.req_size == 2'b11);
  assign oor      = (widx >= NWORDS);
  assign err      = mis | bad_size | oor;

  always_comb begin
    mis = 1'b0;
    unique case (1'b1)
      req.req_size == 2'b01: mis = req.req_addr[0];
      req.req_size == 2'b10: mis = |req.req_addr[1:0];
      default:               mis = 1'b0;
    endcase
  end

  function automatic logic [31:0] load_ext(
    input logic [31:0] w,
    input logic [1:0]  lane,
    input logic [1:0]  sz,
    input logic        uns
  );
    logic [7:0]  b;
    logic [15:0] h;
    b = w[8*lane +: 8];
    h = lane[1] ? w[31:16] : w[15:0];
    unique case (1'b1)
      sz == 2'b00: return uns ? {24'b0, b} : {{24{b[7]}}, b};
      sz == 2'b01: return uns ? {16'b0, h} : {{16{h[15]}}, h};
      default:     return w;
    endcase
  endfunction

  // Only the addressed lane changes; the rest is the word just read.
  function automatic logic [31:0] merge(
    input logic [31:0] w,
    input logic [15:0] d,
    input logic [1:0]  lane,
    input logic [1:0]  sz
  );
    logic [31:0] m;
    m = w;
    if (sz == 2'b00) m[8*lane +: 8] = d[7:0];
    else             m[16*lane[1] +: 16] = d;
    return m;
  endfunction

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      lr          <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (accept) begin
            lr.lane  <= req.req_addr[1:0];
            lr.size  <= req.req_size;
            lr.uns   <= req.req_unsigned;
            lr.wdata <= req.req_wdata[15:0];
            if (err) begin
              rsp_valid_q <= 1'b1;
              rsp_err_q   <= 1'b1;
              rsp_rdata_q <= '0;
              state       <= RESP;
            end else begin
              addr_q <= 32'({widx, 2'b00});
              if (!req.req_we) begin
                state <= LOAD;
              end else if (req.req_size == 2'b10) begin
                we_q    <= 1'b1;
                wdata_q <= req.req_wdata;
                state   <= WRITE;
              end else begin
                state <= RMW_RD;
              end
            end
          end
        end
        LOAD: begin
          rsp_rdata_q <= load_ext(mem.mem_rdata, lr.lane,
                                  lr.size, lr.uns);
          rsp_err_q   <= 1'b0;
          rsp_valid_q <= 1'b1;
          state       <= RESP;
        end
        RMW_RD: begin
          wdata_q <= merge(mem.mem_rdata, lr.wdata,
                           lr.lane, lr.size);
          we_q    <= 1'b1;
          state   <= WRITE;
        end
        WRITE: begin
          we_q        <= 1'b0;
          rsp_valid_q <= 1'b1;
          rsp_err_q   <= 1'b0;
          rsp_rdata_q <= '0;
          state       <= RESP;
        end
        RESP: begin
          rsp_valid_q <= 1'b0;
          rsp_err_q   <= 1'b0;
          rsp_rdata_q <= '0;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef LSU_FAULT_ADDR_EN
  logic [1:0] cause;

  always_comb begin
    cause = 2'b00;
    unique case (1'b1)
      mis:      cause = 2'b01;
      bad_size: cause = 2'b10;
      default:  cause = 2'b11;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fault_addr  <= '0;
      fault_cause <= '0;
    end else if (accept && err) begin
      fault_addr  <= 32'(req.req_addr);
      fault_cause <= cause;
    end
  end
`endif

  // Reset must block a write even mid read-modify-write.
  assign mem.mem_we    = we_q & rst_n;
  assign mem.mem_addr  = addr_q;
  assign mem.mem_wdata = wdata_q;

  assign req.req_ready = ready;
  assign req.rsp_valid = rsp_valid_q;
  assign req.rsp_err   = rsp_err_q;
  assign req.rsp_rdata = rsp_rdata_q;

endmodule
